// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op and FSM state encodings plus the iteration count.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    localparam int unsigned ITERATIONS = 32;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage bundle for the multiply/divide unit: launch, operands,
// MTHI/MTLO direct writes, and HI/LO/status back to the pipeline.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Final sign correction: turns the unsigned magnitude result into the
// signed HI/LO pair for MULT/DIV; unsigned ops pass through.
module mdu_sign_fix
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  op_e                op,
    input  logic               a_sign,
    input  logic               b_sign,
    input  logic               div_zero,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic               sgn;
    logic               prod_neg;
    logic               quot_neg;
    logic               rem_neg;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        sgn      = op_is_signed(op);
        prod_neg = sgn & (a_sign ^ b_sign);
        // A zero divisor must leave the all-ones quotient untouched.
        quot_neg = sgn & (a_sign ^ b_sign) & ~div_zero;
        rem_neg  = sgn & a_sign;
        prod     = prod_neg ? -raw : raw;
        quot     = quot_neg ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        rem      = rem_neg ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        hi       = '0;
        lo       = '0;
        if (op_is_div(op)) begin
            hi = rem;
            lo = quot;
        end else begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One result bit per cycle on magnitudes, sign fixed up in a final state.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    mult_div_unit_if.slave bus
);
    localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

    state_e             state;
    state_e             state_nxt;
    op_e                op_in;
    op_e                op_q;
    logic               sa_q;
    logic               sb_q;
    logic               dz_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [5:0]         cnt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               launch;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] raw;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign op_in  = op_e'(bus.op);
    assign launch = (state == IDLE) && bus.start;
    assign a_neg  = op_is_signed(op_in) & bus.a[WIDTH-1];
    assign b_neg  = op_is_signed(op_in) & bus.b[WIDTH-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;

    // Multiply: acc = {P, multiplier}; divide: acc[WIDTH-1:0] holds dividend/quotient.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};
    assign raw       = op_is_div(op_q) ? {rem, acc[WIDTH-1:0]} : acc;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op       (op_q),
        .a_sign   (sa_q),
        .b_sign   (sb_q),
        .div_zero (dz_q),
        .raw      (raw),
        .hi       (fix_hi),
        .lo       (fix_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == LAST_ITER) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_MULT;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dz_q   <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (launch) begin
                        op_q <= op_in;
                        sa_q <= a_neg;
                        sb_q <= b_neg;
                        dz_q <= (bus.b == '0);
                        rem  <= '0;
                        cnt  <= '0;
                        if (op_is_div(op_in)) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (op_is_div(op_q)) begin
                        // Borrow out of the trial subtract means restore.
                        rem <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_trial[WIDTH]};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
